// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: opcode constants, FSM state encoding and register-use decode
// shared by the hazard detection unit.
package hazard_unit_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_NOP    = 7'b0000000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2
   } state_t;

   function automatic logic uses_rs1(input logic [6:0] op);
      return op inside {OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH};
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return op inside {OP_R, OP_STORE, OP_BRANCH};
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall and taken-branch flush control for a 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int LU_BUBBLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [6:0]  IFID_opcode_i,
   input  logic [4:0]  IFID_rs1_i,
   input  logic [4:0]  IFID_rs2_i,
   input  logic        IDEX_MemRead_i,
   input  logic [4:0]  IDEX_rd_i,
   input  logic        branch_taken_i,
`ifdef HAZARD_STATS_EN
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o,
`endif
   output logic        NoOp_o,
   output logic        Stall_o,
   output logic        PCWrite_o,
   output logic        Flush_o
);

   state_t     r_state;
   logic [1:0] r_bub_cnt;
   logic       w_lu;
   logic       w_run;

   assign w_run = (r_state == S_RUN);
   assign w_lu  = w_run && IDEX_MemRead_i && (IDEX_rd_i != 5'd0) &&
                  ((uses_rs1(IFID_opcode_i) && (IFID_rs1_i == IDEX_rd_i)) ||
                   (uses_rs2(IFID_opcode_i) && (IFID_rs2_i == IDEX_rd_i)));

   // A load-use hit takes priority over a taken branch; the branch is seen again after the stall.
   assign NoOp_o    = !w_run || w_lu;
   assign Stall_o   = (r_state == S_STALL) || w_lu;
   assign PCWrite_o = w_run && !w_lu;
   assign Flush_o   = w_run && !w_lu && (IFID_opcode_i == OP_BRANCH) && branch_taken_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= S_IDLE;
         r_bub_cnt <= 2'd0;
      end else if (!start_i) begin
         r_state   <= S_IDLE;
         r_bub_cnt <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_RUN;
            S_RUN: begin
               if (w_lu && (LU_BUBBLES > 1)) begin
                  r_state   <= S_STALL;
                  r_bub_cnt <= 2'(LU_BUBBLES - 1);
               end
            end
            S_STALL: begin
               r_bub_cnt <= r_bub_cnt - 2'd1;
               if (r_bub_cnt == 2'd1) r_state <= S_RUN;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'(Stall_o && (r_stall_cnt != '1));
         r_flush_cnt <= r_flush_cnt + 32'(Flush_o && (r_flush_cnt != '1));
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
